// File: rtl/bus_pkg.sv
// Shared types and constants for the device-bus arbiter: FSM encoding,
// master identifiers and default widths.
package bus_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int WCNT_W = 4;

    // Code 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Fixed-priority pick with a starvation guard: m0 wins ties until m1 has lost
// MAX_WAIT times in a row, then m1 is forced through.
module arb_pick
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic              req0,
    input  logic              req1,
    input  logic [WCNT_W-1:0] wait_cnt,
    output logic              winner,
    output logic [WCNT_W-1:0] next_wait
);

    localparam logic [WCNT_W-1:0] MAX_W = WCNT_W'(MAX_WAIT);

    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        winner    = M_CPU;
        next_wait = '0;
        unique case ({req1, req0})
            2'b01: winner = M_CPU;
            2'b10: winner = M_AUX;
            2'b11: begin
                if (wait_cnt >= MAX_W) begin
                    winner = M_AUX;
                end else begin
                    winner    = M_CPU;
                    next_wait = wait_cnt + 1'b1;
                end
            end
            default: winner = M_CPU;
        endcase
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter for the peripheral bridge: one registered transaction at
// a time through IDLE -> ACCESS -> RESP, m0 priority with m1 starvation guard.
module dev_bus_arbiter
    import bus_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    input  logic [DW-1:0] bus_rdata,
    output logic          owner,
    output logic          busy
);

    state_t              state, state_next;
    logic [WCNT_W-1:0]   wait_cnt, wait_next;
    logic                winner;
    logic [AW-1:0]       addr_reg;
    logic [DW-1:0]       wdata_reg;
    logic                we_reg;
    logic [DW-1:0]       rdata_reg;
    logic                owner_reg;

    arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .wait_cnt  (wait_cnt),
        .winner    (winner),
        .next_wait (wait_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:   state_next = (m0_req || m1_req) ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: every datapath register is reset; these are flops, not a memory, so clearing them is cheap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            owner_reg <= M_CPU;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (state == ST_IDLE) begin
                wait_cnt <= wait_next;
                if (m0_req || m1_req) begin
                    owner_reg <= winner;
                    addr_reg  <= (winner == M_AUX) ? m1_addr  : m0_addr;
                    wdata_reg <= (winner == M_AUX) ? m1_wdata : m0_wdata;
                    we_reg    <= (winner == M_AUX) ? m1_we    : m0_we;
                end
            end
            // Captured for writes too; masters qualify with their ack.
            if (state == ST_ACCESS) rdata_reg <= bus_rdata;
        end
    end

    always_comb begin
        bus_we = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        busy   = 1'b0;
        case (state)
            ST_ACCESS: begin
                bus_we = we_reg;
                busy   = 1'b1;
            end
            ST_RESP: begin
                m0_ack = (owner_reg == M_CPU);
                m1_ack = (owner_reg == M_AUX);
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign owner     = owner_reg;
    assign m0_rdata  = rdata_reg;
    assign m1_rdata  = rdata_reg;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grants, bus cycle and response.
module tb_dev_bus_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack, bus_we, owner, busy;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction-level model: cycles since grant (-1 = no transaction in flight).
    int          mdl_since = -1;
    int          mdl_losses = 0;
    logic        mdl_owner = 1'b0;
    logic [31:0] mdl_addr = '0, mdl_wdata = '0, mdl_rdata = '0;
    logic        mdl_we = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h0000_7f00) return 32'h0000_1234;
        return {a[15:0] ^ 16'h5a5a, a[31:16] + 16'h1};
    endfunction

    assign bus_rdata = rd_fn(bus_addr);

    dev_bus_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_rdata(bus_rdata), .owner(owner), .busy(busy)
    );

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        logic        r_rst, r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        r_rst = reset; r0 = m0_req; r1 = m1_req; w0 = m0_we; w1 = m1_we;
        a0 = m0_addr; a1 = m1_addr; d0 = m0_wdata; d1 = m1_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (r_rst) begin
            mdl_since = -1; mdl_losses = 0; mdl_owner = 1'b0;
            mdl_addr = '0; mdl_wdata = '0; mdl_we = 1'b0; mdl_rdata = '0;
        end else if (mdl_since == -1) begin
            if (!r1) mdl_losses = 0;
            if (r0 || r1) begin
                if (r0 && (!r1 || mdl_losses < MAX_WAIT)) begin
                    mdl_owner = 1'b0;
                    if (r1) mdl_losses++;
                end else begin
                    mdl_owner = 1'b1;
                    mdl_losses = 0;
                end
                mdl_addr  = mdl_owner ? a1 : a0;
                mdl_wdata = mdl_owner ? d1 : d0;
                mdl_we    = mdl_owner ? w1 : w0;
                mdl_since = 1;
            end
        end else if (mdl_since == 1) begin
            mdl_rdata = rd_fn(mdl_addr);
            mdl_since = 2;
        end else begin
            mdl_since = -1;
        end
    endtask

    task automatic wait_any_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            got = m0_ack | m1_ack;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_tests++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we got %b exp 0", bus_we); end
        n_tests++; if ({m0_ack, m1_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got %b exp 00", {m0_ack, m1_ack}); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner got %b exp 0", owner); end
        n_tests++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
        n_tests++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", m0_rdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_m0_read();
        m0_req = 1'b1; m0_addr = 32'h0000_7f00; m0_wdata = 32'hdead_beef; m0_we = 1'b0;
        tick();
        n_tests++; if (bus_addr !== 32'h0000_7f00 || bus_we !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL m0_read_access addr=%h we=%b busy=%b exp 7f00/0/1", bus_addr, bus_we, busy);
        end
        tick();
        n_tests++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL m0_read_ack m0_ack=%b m1_ack=%b exp 1/0", m0_ack, m1_ack);
        end
        n_tests++; if (m0_rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL m0_read_rdata got %h exp 00001234", m0_rdata); end
        m0_req = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0 || m0_ack !== 1'b0) begin
            n_fail++; $display("FAIL m0_read_idle busy=%b ack=%b exp 0/0", busy, m0_ack);
        end
    endtask

    task automatic test_m1_write();
        m1_req = 1'b1; m1_addr = 32'h0000_7f34; m1_wdata = 32'h0000_00a5; m1_we = 1'b1;
        tick();
        n_tests++; if (bus_we !== 1'b1 || bus_addr !== 32'h0000_7f34 || bus_wdata !== 32'h0000_00a5) begin
            n_fail++; $display("FAIL m1_write_access we=%b addr=%h wdata=%h exp 1/7f34/a5", bus_we, bus_addr, bus_wdata);
        end
        n_tests++; if (owner !== 1'b1) begin n_fail++; $display("FAIL m1_write_owner got %b exp 1", owner); end
        tick();
        n_tests++; if (bus_we !== 1'b0 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            n_fail++; $display("FAIL m1_write_resp we=%b m1_ack=%b m0_ack=%b exp 0/1/0", bus_we, m1_ack, m0_ack);
        end
        m1_req = 1'b0;
        tick();
    endtask

    task automatic test_both_held();
        logic exp_order [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic got_order [$];
        int   got_cyc   [$];
        m0_req = 1'b1; m0_addr = 32'h100; m0_we = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h200; m1_we = 1'b0;
        for (int i = 0; i < 60 && got_order.size() < 8; i++) begin
            tick();
            if (m0_ack || m1_ack) begin
                got_order.push_back(m1_ack);
                got_cyc.push_back(cyc);
            end
        end
        n_tests++; if (got_order.size() != 8) begin
            n_fail++; $display("FAIL both_held_count got %0d acks exp 8", got_order.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++; if (got_order[i] !== exp_order[i]) begin
                    n_fail++; $display("FAIL both_held_order idx=%0d got m%0d exp m%0d", i, got_order[i], exp_order[i]);
                end
                if (i > 0) begin
                    n_tests++; if (got_cyc[i] - got_cyc[i-1] != 3) begin
                        n_fail++; $display("FAIL both_held_spacing idx=%0d got %0d exp 3", i, got_cyc[i] - got_cyc[i-1]);
                    end
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_m1_alone();
        bit got;
        m1_req = 1'b1; m1_addr = 32'h300; m1_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_any_ack(got);
            n_tests++; if (!got || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
                n_fail++; $display("FAIL m1_alone_grant idx=%0d got=%0b m1_ack=%b m0_ack=%b exp 1/1/0", i, got, m1_ack, m0_ack);
            end
            n_tests++; if (dut.wait_cnt !== 4'd0) begin
                n_fail++; $display("FAIL m1_alone_wait idx=%0d got %0d exp 0", i, dut.wait_cnt);
            end
        end
        m0_req = 1'b1; m0_addr = 32'h400; m0_we = 1'b0;
        wait_any_ack(got);
        n_tests++; if (!got || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL m1_alone_then_both got=%0b m0_ack=%b m1_ack=%b exp 1/1/0", got, m0_ack, m1_ack);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_addr = 32'h0000_7f10; m0_wdata = 32'h55; m0_we = 1'b1;
        tick();
        n_tests++; if (bus_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_access we=%b exp 1", bus_we); end
        reset = 1'b1;
        tick();
        n_tests++; if (bus_we !== 1'b0 || m0_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_abort we=%b ack=%b busy=%b exp 0/0/0", bus_we, m0_ack, busy);
        end
        reset = 1'b0;
        tick();
        n_tests++; if (bus_we !== 1'b1 || bus_addr !== 32'h0000_7f10 || m0_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_reissue we=%b addr=%h ack=%b exp 1/7f10/0", bus_we, bus_addr, m0_ack);
        end
        tick();
        n_tests++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ack got %b exp 1", m0_ack); end
        m0_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        m0_req = 1'b1; m0_addr = 32'h0000_7f00; m0_we = 1'b0;
        tick();
        m0_addr = 32'h0000_7f40;
        n_tests++; if (bus_addr !== 32'h0000_7f00) begin n_fail++; $display("FAIL addr_hold_access got %h exp 7f00", bus_addr); end
        tick();
        n_tests++; if (bus_addr !== 32'h0000_7f00 || m0_ack !== 1'b1) begin
            n_fail++; $display("FAIL addr_hold_resp addr=%h ack=%b exp 7f00/1", bus_addr, m0_ack);
        end
        tick(); tick();
        n_tests++; if (bus_addr !== 32'h0000_7f40 || busy !== 1'b1) begin
            n_fail++; $display("FAIL addr_next_txn addr=%h busy=%b exp 7f40/1", bus_addr, busy);
        end
        tick();
        m0_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!m0_req && $urandom_range(0, 2) == 0) begin
                m0_req = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom_range(0, 1));
            end
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                m1_req = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom_range(0, 1));
            end
            tick();
            n_tests++; if (busy !== (mdl_since != -1)) begin
                n_fail++; $display("FAIL rand_busy cyc=%0d got %b exp %b", cyc, busy, mdl_since != -1);
            end
            n_tests++; if (owner !== mdl_owner) begin
                n_fail++; $display("FAIL rand_owner cyc=%0d got %b exp %b", cyc, owner, mdl_owner);
            end
            n_tests++; if (bus_we !== (mdl_since == 1 && mdl_we)) begin
                n_fail++; $display("FAIL rand_bus_we cyc=%0d got %b exp %b", cyc, bus_we, mdl_since == 1 && mdl_we);
            end
            n_tests++; if (bus_addr !== mdl_addr || bus_wdata !== mdl_wdata) begin
                n_fail++; $display("FAIL rand_bus_addr cyc=%0d got %h/%h exp %h/%h", cyc, bus_addr, bus_wdata, mdl_addr, mdl_wdata);
            end
            n_tests++; if (m0_ack !== (mdl_since == 2 && !mdl_owner) || m1_ack !== (mdl_since == 2 && mdl_owner)) begin
                n_fail++; $display("FAIL rand_acks cyc=%0d got %b%b exp %b%b", cyc, m0_ack, m1_ack,
                                   mdl_since == 2 && !mdl_owner, mdl_since == 2 && mdl_owner);
            end
            n_tests++; if (m0_rdata !== mdl_rdata || m1_rdata !== mdl_rdata) begin
                n_fail++; $display("FAIL rand_rdata cyc=%0d got %h/%h exp %h", cyc, m0_rdata, m1_rdata, mdl_rdata);
            end
            if (m0_ack) begin
                if ($urandom_range(0, 1) == 1) begin
                    m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom_range(0, 1));
                end else m0_req = 1'b0;
            end
            if (m1_ack) begin
                if ($urandom_range(0, 1) == 1) begin
                    m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom_range(0, 1));
                end else m1_req = 1'b0;
            end
        end
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_we = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_we = 1'b0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_both_held();
        test_m1_alone();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Two-master arbiter in front of the peripheral bridge.
- Shares the single device bus (address, write data, write enable, read data) between the CPU data port (m0) and a secondary master (m1), such as a debug loader or DMA engine.
- Serialises one transaction at a time with registered request capture and registered read data.
- Fixed priority to m0, with a starvation guard that guarantees m1 service.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 3, number of consecutive lost arbitrations m1 tolerates before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU request; held with addr/wdata/we stable until m0_ack.
- m0_addr  in  AW  CPU address.
- m0_wdata  in  DW  CPU write data.
- m0_we  in  1  CPU write enable (0 = read).
- m0_ack  out  1  one-cycle completion pulse to CPU.
- m0_rdata  out  DW  read data; valid when m0_ack=1.
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_rdata  same as the m0 ports, for the secondary master.
- bus_addr  out  AW  address to the bridge.
- bus_wdata  out  DW  write data to the bridge.
- bus_we  out  1  write strobe to the bridge.
- bus_rdata  in  DW  combinational read data from the bridge.
- owner  out  1  master currently holding or last holding the bus (0 = m0).
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset values (next edge with reset=1):
  - state=IDLE; wait_cnt=0; owner=0.
  - Address, data and we registers = 0; rdata_reg = 0.
  - All acks=0; bus_we=0; busy=0.
- States: IDLE -> ACCESS -> RESP -> IDLE. One transaction every 3 cycles at best.
- IDLE:
  - If any req is high, pick a winner using the arbitration rule below.
  - Latch the winner's addr, wdata and we into registers, set owner, and go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - bus_addr/bus_wdata are driven from the latched registers.
  - bus_we = latched we, high for exactly this one cycle.
  - At the end of the cycle, rdata_reg <= bus_rdata, captured for writes too.
  - Go to RESP.
- RESP:
  - The owner's ack=1 for exactly this cycle; the other master's ack=0.
  - Go to IDLE.
- bus_addr/bus_wdata keep their latched values outside ACCESS; bus_we=0 outside ACCESS.
- m0_rdata = m1_rdata = rdata_reg. Masters qualify it with their own ack.
- Input changes after the grant are ignored until the next IDLE sample.
- Request latency: req sampled high in IDLE at cycle N -> bus_we/addr valid in cycle N+1 -> ack in cycle N+2.
- Arbitration (evaluated only in IDLE):
  - Only m0_req high -> m0.
  - Only m1_req high -> m1.
  - Both high and wait_cnt < MAX_WAIT -> m0, and wait_cnt increments.
  - Both high and wait_cnt == MAX_WAIT -> m1.
  - wait_cnt clears to 0 whenever m1 is granted, and in any IDLE cycle where m1_req=0.
  - wait_cnt never exceeds MAX_WAIT (4-bit counter).
- A master keeping req high after its ack re-arbitrates in the following IDLE cycle. No back-to-back grant without passing through IDLE.
- Reset mid-transaction: any state -> IDLE on the next edge.
  - bus_we drops in the cycle after reset is sampled.
  - The aborted transaction produces no ack; the master must re-request.
- Address and data are passed through unmodified. The bridge decodes them.

Decomposition:
- Shared package bus_pkg:
  - AW/DW defaults.
  - State encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2. Code 3 is illegal and recovers to IDLE.
  - Master IDs M_CPU=1'b0, M_AUX=1'b1.
- One natural sub-module: arb_pick. It is combinational; it takes req0, req1, wait_cnt and MAX_WAIT and outputs the winner id and the next wait_cnt. This keeps the fairness rule unit-testable.
- The FSM and datapath registers stay in dev_bus_arbiter.

Test Plan:
- m0 read, addr 0x0000_7f00, bridge returns 0x0000_1234:
  - bus_addr=0x7f00 with bus_we=0 in cycle N+1.
  - m0_ack=1 and m0_rdata=0x1234 in cycle N+2; m1_ack stays 0.
- m1 write, addr 0x7f34, wdata 0x0000_00a5:
  - bus_we high for exactly one cycle, with bus_addr=0x7f34 and bus_wdata=0xa5.
  - m1_ack in the next cycle; owner=1.
- Both reqs held high continuously with MAX_WAIT=3:
  - Grant order m0,m0,m0,m1,m0,m0,m0,m1.
  - Each ack spaced 3 cycles apart.
- m1 requesting alone for 5 transactions:
  - All granted to m1; wait_cnt stays 0.
  - A later both-high arbitration grants m0 first.
- Reset asserted during the ACCESS cycle of an m0 write:
  - bus_we=0 next cycle; no m0_ack; state IDLE.
  - After reset release, the held m0_req is re-served with full N+2 latency.
- m0 changes addr from 0x7f00 to 0x7f40 the cycle after grant:
  - bus_addr stays 0x7f00 for this transaction.
  - The next transaction uses 0x7f40.
